// File: rtl/img_read_master_if.sv
// Pool-side read port bundle: request (group/bank_en/addr/addr_ready) and response (data_valid/data/data_ready).
// The master modport is the initiator; the slave modport is the image pool.
interface img_read_master_if #(
   parameter int IMG_GRP_NUM = 3,
   parameter int ROW_PARA    = 4,
   parameter int AW          = 48,
   parameter int DW          = 256
) ();
   logic [IMG_GRP_NUM-1:0] group_id;
   logic [ROW_PARA-1:0]    bank_en;
   logic [AW-1:0]          addr;
   logic                   addr_ready;
   logic                   data_valid;
   logic [DW-1:0]          data;
   logic                   data_ready;

   modport master (
      output group_id, bank_en, addr, data_ready,
      input  addr_ready, data_valid, data
   );

   modport slave (
      input  group_id, bank_en, addr, data_ready,
      output addr_ready, data_valid, data
   );
endinterface

// File: rtl/img_read_master.sv
// Burst read initiator for one image-pool client: issues credit-limited row reads and streams rows out.
// Optional feature macro: IMG_RD_STRIDE_EN (adds cmd_stride_i; otherwise the address step is 1).
module img_read_master #(
   parameter int IMG_GRP_NUM     = 3,
   parameter int ROW_PARA        = 4,
   parameter int CHL_PARA        = 8,
   parameter int BANK_ADDR_WIDTH = 12,
   parameter int BANK_UNIT_WIDTH = 8,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                                        clk,
   input  logic                                        rst_p,
   input  logic                                        cmd_valid_i,
   output logic                                        cmd_ready_o,
   input  logic [IMG_GRP_NUM-1:0]                      cmd_group_id_i,
   input  logic [ROW_PARA-1:0]                         cmd_bank_en_i,
   input  logic [BANK_ADDR_WIDTH-1:0]                  cmd_base_addr_i,
   input  logic [BANK_ADDR_WIDTH:0]                    cmd_len_i,
`ifdef IMG_RD_STRIDE_EN
   input  logic [BANK_ADDR_WIDTH-1:0]                  cmd_stride_i,
`endif
   img_read_master_if.master                           rd,
   output logic                                        out_valid_o,
   output logic [ROW_PARA*CHL_PARA*BANK_UNIT_WIDTH-1:0] out_data_o,
   output logic                                        out_last_o,
   input  logic                                        out_ready_i,
   output logic                                        done_o
);
   localparam int DW  = ROW_PARA * CHL_PARA * BANK_UNIT_WIDTH;
   localparam int BAW = BANK_ADDR_WIDTH;
   localparam int LW  = BANK_ADDR_WIDTH + 1;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW:0]   DEPTH_CX = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [IMG_GRP_NUM-1:0] group_q;
   logic [ROW_PARA-1:0]  bank_en_q;
   logic [BAW-1:0]       addr_q;
   logic [LW-1:0]        len_q, issued_q, received_q;
   logic [CW-1:0]        outstanding_q, count_q;
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [DW:0]          mem_q [FIFO_DEPTH];
   logic                 zero_done_q;
   logic [BAW-1:0]       step;

   logic                 cmd_fire, credit, req_fire, resp_fire, pop_fire, last_pop;
   logic                 issue_last, resp_last, full;
   logic [CW:0]          inflight;
   logic [ROW_PARA-1:0]  req_bank_en;
   logic [DW:0]          head;

`ifdef IMG_RD_STRIDE_EN
   logic [BAW-1:0] stride_q;
   always_ff @(posedge clk) begin
      if (rst_p) stride_q <= '0;
      else if (cmd_fire) stride_q <= cmd_stride_i;
   end
   assign step = stride_q;
`else
   assign step = BAW'(1);
`endif

   // Requests in flight plus words parked in the FIFO can never exceed its depth.
   assign inflight    = {1'b0, outstanding_q} + {1'b0, count_q};
   assign credit      = inflight < DEPTH_CX;
   assign req_bank_en = (state_q == ISSUE && credit) ? bank_en_q : '0;
   assign req_fire    = (|req_bank_en) && rd.addr_ready;
   assign issue_last  = (issued_q + LW'(1)) == len_q;
   assign resp_last   = (received_q + LW'(1)) == len_q;

   assign rd.bank_en    = req_bank_en;
   assign rd.group_id   = (|req_bank_en) ? group_q : '0;
   assign rd.addr       = {ROW_PARA{addr_q}};
   assign full          = count_q == DEPTH_C;
   assign rd.data_ready = (state_q != IDLE) && !full;
   assign resp_fire     = rd.data_valid && rd.data_ready;

   assign head        = mem_q[rd_ptr_q];
   assign out_valid_o = count_q != '0;
   assign out_last_o  = out_valid_o && head[DW];
   assign out_data_o  = out_valid_o ? head[DW-1:0] : '0;
   assign pop_fire    = out_valid_o && out_ready_i;
   assign last_pop    = pop_fire && out_last_o && (state_q != IDLE);
   assign done_o      = zero_done_q || last_pop;

   always_comb begin
      state_d     = state_q;
      cmd_ready_o = 1'b0;
      cmd_fire    = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            cmd_fire    = cmd_valid_i;
            if (cmd_valid_i && cmd_len_i != '0) state_d = ISSUE;
         end
         ISSUE: if (req_fire && issue_last) state_d = DRAIN;
         DRAIN: if (last_pop) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_p) begin
         state_q       <= IDLE;
         group_q       <= '0;
         bank_en_q     <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         issued_q      <= '0;
         received_q    <= '0;
         outstanding_q <= '0;
         zero_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         zero_done_q <= cmd_fire && (cmd_len_i == '0);
         if (cmd_fire) begin
            group_q    <= cmd_group_id_i;
            bank_en_q  <= cmd_bank_en_i;
            addr_q     <= cmd_base_addr_i;
            len_q      <= cmd_len_i;
            issued_q   <= '0;
            received_q <= '0;
         end else begin
            if (req_fire) begin
               addr_q   <= addr_q + step;
               issued_q <= issued_q + LW'(1);
            end
            if (resp_fire) received_q <= received_q + LW'(1);
         end
         if (req_fire && !resp_fire) outstanding_q <= outstanding_q + CW'(1);
         else if (!req_fire && resp_fire) outstanding_q <= outstanding_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_p) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (resp_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_fire) rd_ptr_q <= rd_ptr_q + PW'(1);
         if (resp_fire && !pop_fire) count_q <= count_q + CW'(1);
         else if (!resp_fire && pop_fire) count_q <= count_q - CW'(1);
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (resp_fire) mem_q[wr_ptr_q] <= {resp_last, rd.data};
   end
endmodule

// File: tb/tb_img_read_master.sv
// Self-checking bench for img_read_master: directed scenarios plus random bursts against an address/data model.
module tb_img_read_master;
   localparam int GN = 3, RP = 4, CP = 8, BAW = 12, BUW = 8, FD = 4;
   localparam int DW = RP * CP * BUW;
   localparam int AW = RP * BAW;
   localparam int LW = BAW + 1;

   logic clk = 1'b0;
   logic rst_p = 1'b1;
   always #5 clk = ~clk;

   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [GN-1:0]  cmd_grp = '0;
   logic [RP-1:0]  cmd_ben = '0;
   logic [BAW-1:0] cmd_base = '0;
   logic [LW-1:0]  cmd_len = '0;
`ifdef IMG_RD_STRIDE_EN
   logic [BAW-1:0] cmd_stride = '0;
`endif
   logic           out_valid, out_last, done;
   logic           out_ready;
   logic [DW-1:0]  out_data;

   img_read_master_if #(.IMG_GRP_NUM(GN), .ROW_PARA(RP), .AW(AW), .DW(DW)) pif ();

   img_read_master #(
      .IMG_GRP_NUM(GN), .ROW_PARA(RP), .CHL_PARA(CP),
      .BANK_ADDR_WIDTH(BAW), .BANK_UNIT_WIDTH(BUW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_p(rst_p),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_group_id_i(cmd_grp), .cmd_bank_en_i(cmd_ben),
      .cmd_base_addr_i(cmd_base), .cmd_len_i(cmd_len),
`ifdef IMG_RD_STRIDE_EN
      .cmd_stride_i(cmd_stride),
`endif
      .rd(pif),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
      .out_ready_i(out_ready), .done_o(done)
   );

   int total = 0;
   int bad   = 0;

   // burst expectations
   logic [GN-1:0] e_grp;
   logic [RP-1:0] e_ben;
   int            e_base, e_len, e_step;
   logic [31:0]   salt = 32'h1234_5678;

   // ready-pattern modes: 0 always high, 1 toggle/hold low, 2 random
   int ar_mode = 0;
   int or_mode = 0;

   typedef struct { int due; logic [DW-1:0] d; } pend_t;
   pend_t pend[$];
   bit    pool_pop = 0;

   int            ncyc = 0;
   bit            crdy_hist[$];
   int            cmd_cyc[$], acc_cyc[$], push_cyc[$], out_cyc[$], done_cyc[$];
   logic [BAW-1:0] acc_addr[$];
   logic [RP-1:0] acc_ben[$];
   logic [GN-1:0] acc_grp[$];
   logic [DW-1:0] mon_data[$];
   bit            mon_last[$];
   int            stab_err = 0, slice_err = 0, grp_err = 0;
   bit            prev_stall = 0;
   logic [RP-1:0] prev_ben;
   logic [AW-1:0] prev_addr;
   logic [GN-1:0] prev_grp;

   function automatic logic [DW-1:0] pool_word(input logic [BAW-1:0] a, input logic [31:0] s);
      logic [DW-1:0] w;
      for (int k = 0; k < DW / 32; k++)
         w[k*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ s ^ (32'(k) << 20) ^ 32'(a);
      return w;
   endfunction

   // Handshake monitor: values sampled here are those the DUT registers at the next rising edge.
   always @(negedge clk) begin
      crdy_hist.push_back(cmd_ready);
      if (rst_p) begin
         pend.delete();
         pool_pop   = 0;
         prev_stall = 0;
      end else begin
         if (cmd_valid && cmd_ready) cmd_cyc.push_back(ncyc);
         if (pif.bank_en != '0) begin
            for (int s = 1; s < RP; s++)
               if (pif.addr[s*BAW +: BAW] !== pif.addr[BAW-1:0]) slice_err++;
         end else if (pif.group_id != '0) grp_err++;
         if (prev_stall && (pif.bank_en !== prev_ben || pif.addr !== prev_addr || pif.group_id !== prev_grp))
            stab_err++;
         prev_stall = (pif.bank_en != '0) && !pif.addr_ready;
         prev_ben   = pif.bank_en;
         prev_addr  = pif.addr;
         prev_grp   = pif.group_id;
         if (pif.bank_en != '0 && pif.addr_ready) begin
            acc_addr.push_back(pif.addr[BAW-1:0]);
            acc_ben.push_back(pif.bank_en);
            acc_grp.push_back(pif.group_id);
            acc_cyc.push_back(ncyc);
            pend.push_back('{ncyc + 2, pool_word(pif.addr[BAW-1:0], salt)});
         end
         if (pif.data_valid && pif.data_ready) begin
            push_cyc.push_back(ncyc);
            pool_pop = 1;
         end
         if (out_valid && out_ready) begin
            mon_data.push_back(out_data);
            mon_last.push_back(out_last);
            out_cyc.push_back(ncyc);
         end
         if (done) done_cyc.push_back(ncyc);
      end
      ncyc++;
   end

   // Pool responder and ready-pattern driver.
   initial begin
      pif.addr_ready = 1'b1;
      pif.data_valid = 1'b0;
      pif.data       = '0;
      out_ready      = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (pool_pop) begin
            void'(pend.pop_front());
            pool_pop = 0;
         end
         if (pend.size() > 0 && pend[0].due <= ncyc) begin
            pif.data_valid = 1'b1;
            pif.data       = pend[0].d;
         end else begin
            pif.data_valid = 1'b0;
            pif.data       = '0;
         end
         case (ar_mode)
            0: pif.addr_ready = 1'b1;
            1: pif.addr_ready = ~pif.addr_ready;
            default: pif.addr_ready = 1'($urandom_range(0, 1));
         endcase
         case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_mon();
      cmd_cyc.delete(); acc_cyc.delete(); push_cyc.delete(); out_cyc.delete(); done_cyc.delete();
      acc_addr.delete(); acc_ben.delete(); acc_grp.delete(); mon_data.delete(); mon_last.delete();
      stab_err = 0; slice_err = 0; grp_err = 0;
   endtask

   task automatic send_cmd(input string tag, input logic [GN-1:0] g, input logic [RP-1:0] b,
                           input int base, input int len, input int stride);
      bit seen = 0;
      e_grp = g; e_ben = b; e_base = base; e_len = len;
`ifdef IMG_RD_STRIDE_EN
      e_step = stride;
      cmd_stride = BAW'(stride);
`else
      e_step = 1;
`endif
      salt     = $urandom;
      cmd_grp  = g;
      cmd_ben  = b;
      cmd_base = BAW'(base);
      cmd_len  = LW'(len);
      cmd_valid = 1'b1;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = cmd_ready;
         tick();
      end
      cmd_valid = 1'b0;
      chk({tag, "_cmd_accept"}, seen, 1);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 1000 && done_cyc.size() == 0; i++) tick();
      chk({tag, "_done_seen"}, done_cyc.size() != 0, 1);
      repeat (3) tick();
   endtask

   task automatic check_burst(input string tag);
      logic [BAW-1:0] ea;
      chk({tag, "_nacc"}, acc_addr.size(), e_len);
      for (int i = 0; i < e_len && i < acc_addr.size(); i++) begin
         ea = BAW'(e_base + i * e_step);
         chk($sformatf("%s_addr%0d", tag, i), acc_addr[i], ea);
         chk($sformatf("%s_ben%0d", tag, i), acc_ben[i], e_ben);
         chk($sformatf("%s_grp%0d", tag, i), acc_grp[i], e_grp);
      end
      chk({tag, "_nout"}, mon_data.size(), e_len);
      for (int i = 0; i < e_len && i < mon_data.size(); i++) begin
         ea = BAW'(e_base + i * e_step);
         chk($sformatf("%s_data%0d", tag, i), mon_data[i], pool_word(ea, salt));
         chk($sformatf("%s_last%0d", tag, i), mon_last[i], (i == e_len - 1));
      end
      chk({tag, "_ndone"}, done_cyc.size(), 1);
      chk({tag, "_proto_err"}, stab_err + slice_err + grp_err, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      @(negedge clk);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_bank_en"}, pif.bank_en, 0);
      chk({tag, "_group"}, pif.group_id, 0);
      chk({tag, "_addr"}, pif.addr, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_data_ready"}, pif.data_ready, 0);
   endtask

   initial begin
      int zeros;
      int g, b, base, len, st;

      repeat (3) tick();
      check_reset_vals("rst");
      tick();
      rst_p = 1'b0;
      repeat (2) tick();

      // Basic burst with latency checks
      clear_mon();
      send_cmd("t1", 3'b010, 4'hF, 'h010, 4, 1);
      wait_done("t1");
      check_burst("t1");
      if (cmd_cyc.size() == 1 && acc_cyc.size() == 4 && out_cyc.size() == 4 &&
          push_cyc.size() == 4 && done_cyc.size() == 1) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_acc_cyc%0d", i), acc_cyc[i], cmd_cyc[0] + 1 + i);
            chk($sformatf("t1_out_lat%0d", i), out_cyc[i], push_cyc[i] + 1);
         end
         chk("t1_done_on_last_pop", done_cyc[0], out_cyc[3]);
         chk("t1_cmd_ready_at_done", crdy_hist[done_cyc[0]], 0);
         chk("t1_cmd_ready_after_done", crdy_hist[done_cyc[0] + 1], 1);
      end

      // Zero-length command
      clear_mon();
      send_cmd("t2", 3'b001, 4'h3, 'h123, 0, 1);
      wait_done("t2");
      check_burst("t2");
      if (cmd_cyc.size() == 1 && done_cyc.size() == 1) begin
         chk("t2_done_cyc", done_cyc[0], cmd_cyc[0] + 1);
         zeros = 0;
         for (int c = cmd_cyc[0]; c <= done_cyc[0] + 1; c++) if (!crdy_hist[c]) zeros++;
         chk("t2_cmd_ready_low_cycles", zeros, 0);
      end

      // Address wrap
      clear_mon();
      send_cmd("t3", 3'b100, 4'h5, 'hFFE, 4, 1);
      wait_done("t3");
      check_burst("t3");

      // Credit limit with consumer stalled
      or_mode = 1;
      tick();
      clear_mon();
      send_cmd("t4", 3'b010, 4'hF, 'h200, 8, 1);
      repeat (30) tick();
      chk("t4_credit_accepts", acc_addr.size(), FD);
      @(negedge clk);
      chk("t4_bank_en_held_low", pif.bank_en, 0);
      tick();
      or_mode = 0;
      wait_done("t4");
      check_burst("t4");

      // Request stalls with addr_ready toggling
      ar_mode = 1;
      clear_mon();
      send_cmd("t5", 3'b001, 4'hA, 'h0F0, 6, 1);
      wait_done("t5");
      check_burst("t5");
      ar_mode = 0;
      tick();

      // Reset mid-burst, then a clean burst
      clear_mon();
      send_cmd("t6", 3'b100, 4'hF, 'h300, 8, 1);
      for (int i = 0; i < 50 && acc_addr.size() < 3; i++) tick();
      chk("t6_progress_before_reset", acc_addr.size() >= 3, 1);
      rst_p = 1'b1;
      tick();
      rst_p = 1'b0;
      check_reset_vals("t6_rst");
      repeat (20) tick();
      chk("t6_no_done_after_reset", done_cyc.size(), 0);
      clear_mon();
      send_cmd("t6b", 3'b010, 4'h6, 'h400, 5, 1);
      wait_done("t6b");
      check_burst("t6b");

`ifdef IMG_RD_STRIDE_EN
      clear_mon();
      send_cmd("t7", 3'b001, 4'hF, 0, 3, 3);
      wait_done("t7");
      check_burst("t7");
      clear_mon();
      send_cmd("t7z", 3'b001, 4'h1, 'h055, 3, 0);
      wait_done("t7z");
      check_burst("t7z");
`endif

      // Random bursts with random ready patterns
      ar_mode = 2;
      or_mode = 2;
      for (int r = 0; r < 6; r++) begin
         g    = 1 << $urandom_range(0, GN - 1);
         b    = $urandom_range(1, 15);
         base = $urandom_range(0, 4095);
         len  = $urandom_range(1, 12);
         st   = $urandom_range(0, 7);
         clear_mon();
         send_cmd($sformatf("rnd%0d", r), GN'(g), RP'(b), base, len, st);
         wait_done($sformatf("rnd%0d", r));
         check_burst($sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
